// File: rtl/tick_pkg.sv
// tick_pkg: shared types and widths for the tick divider bank
package tick_pkg;
  typedef enum logic {IDLE, RUN} chan_state_t;
  typedef enum logic {PERIODIC, ONESHOT} tick_mode_t;
  localparam int TS_WIDTH = 32;
endpackage

// File: rtl/tick_channel.sv
// tick_channel: one programmable divider with periodic or one-shot mode
module tick_channel
  import tick_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             int_osc,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_period,
  input  logic             wr_mode,
  input  logic             wr_start,
  input  logic             stop,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] count
);
  chan_state_t      state, state_n;
  tick_mode_t       mode;
  logic [WIDTH-1:0] period, period_m1, count_n;
  logic             tick_n, term, start;
  always_ff @(posedge int_osc or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      mode   <= PERIODIC;
      period <= '0;
      count  <= '0;
      tick   <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      tick  <= tick_n;
      if (wr) begin
        period <= wr_period;
        mode   <= tick_mode_t'(wr_mode);
      end
    end
  // period 0 wraps to all-ones here, giving a full 2^WIDTH cycle
  assign period_m1 = period - WIDTH'(1);
  assign term      = count >= period_m1;
  assign start     = wr && wr_start;
  always_comb begin
    state_n = stop ? IDLE : start ? RUN : (state == RUN && term && mode == ONESHOT) ? IDLE : state;
    count_n = (stop || start || state == IDLE || term) ? '0 : count + WIDTH'(1);
    tick_n  = !stop && !start && state == RUN && term;
  end
  always_comb busy = state == RUN;
endmodule

// File: rtl/tick_divider_bank.sv
// tick_divider_bank: NCH independent tick dividers plus a free-running timestamp
module tick_divider_bank
  import tick_pkg::*;
#(
  parameter int  NCH   = 4,
  parameter int  WIDTH = 24,
  localparam int CW    = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic                   int_osc,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [CW-1:0]          wr_ch,
  input  logic [WIDTH-1:0]       wr_period,
  input  logic                   wr_mode,
  input  logic                   wr_start,
  input  logic [NCH-1:0]         stop,
  output logic [NCH-1:0]         tick,
  output logic [NCH-1:0]         busy,
  output logic [NCH*WIDTH-1:0]   count,
  output logic [TS_WIDTH-1:0]    timestamp
);
  always_ff @(posedge int_osc or negedge reset)
    if (!reset) timestamp <= '0;
    else timestamp <= timestamp + TS_WIDTH'(1);
  // out-of-range channel numbers match no decode and are dropped
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tick_channel #(.WIDTH(WIDTH)) u_ch (
      .int_osc  (int_osc),
      .reset    (reset),
      .wr       (wr_en && wr_ch == CW'(i)),
      .wr_period(wr_period),
      .wr_mode  (wr_mode),
      .wr_start (wr_start),
      .stop     (stop[i]),
      .tick     (tick[i]),
      .busy     (busy[i]),
      .count    (count[i*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_tick_divider_bank.sv
// tb_tick_divider_bank: scoreboard bench for the tick divider bank
module tb_tick_divider_bank;
  logic        int_osc = 1'b0, reset = 1'b0;
  logic        wr_en, wr_mode, wr_start, wr_en2;
  logic [1:0]  wr_ch, wr_ch2;
  logic [23:0] wr_period;
  logic [3:0]  stop, tick, busy;
  logic [95:0] count;
  logic [31:0] timestamp, ts2;
  logic [2:0]  stop2, tick2, busy2;
  logic [11:0] count2;
  logic        quiet;
  typedef struct {int d; int ch; logic tk; logic bz; logic [31:0] cnt;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  always #5 int_osc = ~int_osc;
  tick_divider_bank #(.NCH(4), .WIDTH(24)) dut (
    .int_osc(int_osc), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_period(wr_period),
    .wr_mode(wr_mode), .wr_start(wr_start), .stop(stop), .tick(tick), .busy(busy),
    .count(count), .timestamp(timestamp)
  );
  tick_divider_bank #(.NCH(3), .WIDTH(4)) dut2 (
    .int_osc(int_osc), .reset(reset), .wr_en(wr_en2), .wr_ch(wr_ch2), .wr_period(wr_period[3:0]),
    .wr_mode(wr_mode), .wr_start(wr_start), .stop(stop2), .tick(tick2), .busy(busy2),
    .count(count2), .timestamp(ts2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input int d, input int ch, input logic tk, input logic bz, input logic [31:0] cnt);
    exp_t e;
    e.d = d; e.ch = ch; e.tk = tk; e.bz = bz; e.cnt = cnt;
    sb.push_back(e);
  endtask
  // expected view k cycles after the start edge, derived from period and mode
  task automatic push_seq(input int d, input int ch, input int p, input bit one, input int n);
    for (int k = 0; k < n; k++)
      if (one && k >= p) push(d, ch, k == p, 1'b0, 0);
      else push(d, ch, k > 0 && k % p == 0, 1'b1, k % p);
  endtask
  task automatic wr(input int d, input int ch, input int p, input bit md, input bit st);
    if (d == 0) begin wr_en = 1'b1; wr_ch = ch[1:0]; end
    else begin wr_en2 = 1'b1; wr_ch2 = ch[1:0]; end
    wr_period = p[23:0];
    wr_mode   = md;
    wr_start  = st;
  endtask
  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      @(posedge int_osc);
      #1;
      wr_en = 1'b0; wr_en2 = 1'b0; wr_start = 1'b0; stop = '0; stop2 = '0;
      e = sb.pop_front();
      if (e.d == 0) begin
        chk({tag, ".tick"}, 32'(tick[e.ch]), 32'(e.tk));
        chk({tag, ".busy"}, 32'(busy[e.ch]), 32'(e.bz));
        chk({tag, ".count"}, 32'(count[e.ch*24 +: 24]), e.cnt);
      end else begin
        chk({tag, ".tick"}, 32'(tick2[e.ch]), 32'(e.tk));
        chk({tag, ".busy"}, 32'(busy2[e.ch]), 32'(e.bz));
        chk({tag, ".count"}, 32'(count2[e.ch*4 +: 4]), e.cnt);
      end
    end
  endtask
  initial begin
    wr_en = 1'b0; wr_en2 = 1'b0; wr_ch = '0; wr_ch2 = '0; wr_period = '0;
    wr_mode = 1'b0; wr_start = 1'b0; stop = '0; stop2 = '0;
    repeat (3) @(posedge int_osc);
    #1;
    chk("rst.outs", 32'(|{tick, busy, count, tick2, busy2, count2}), 0);
    chk("rst.ts", timestamp, 0);
    chk("rst.ts2", ts2, 0);
    reset = 1'b1;
    quiet = 1'b0;
    repeat (100) begin
      @(posedge int_osc);
      #1;
      quiet = quiet | (|{tick, busy, count, tick2, busy2, count2});
    end
    chk("idle.quiet", 32'(quiet), 0);
    chk("idle.ts100", timestamp, 100);
    wr(0, 0, 5, 1'b0, 1'b1);
    push_seq(0, 0, 5, 1'b0, 17);
    drain("p5");
    stop[0] = 1'b1;
    push(0, 0, 1'b0, 1'b0, 0);
    drain("stop0");
    wr(0, 1, 3, 1'b1, 1'b1);
    push_seq(0, 1, 3, 1'b1, 24);
    drain("os3");
    wr(0, 2, 100, 1'b0, 1'b1);
    push_seq(0, 2, 100, 1'b0, 51);
    drain("p100");
    wr(0, 2, 10, 1'b0, 1'b0);
    push(0, 2, 1'b0, 1'b1, 51);
    for (int j = 0; j <= 20; j++) push(0, 2, j % 10 == 0, 1'b1, j % 10);
    drain("shrink");
    stop[2] = 1'b1;
    push(0, 2, 1'b0, 1'b0, 0);
    drain("stop2");
    stop[3] = 1'b1;
    wr(0, 3, 4, 1'b0, 1'b1);
    repeat (3) push(0, 3, 1'b0, 1'b0, 0);
    drain("stopwin");
    chk("stopwin.period", 32'(dut.g_ch[3].u_ch.period), 4);
    wr(0, 3, 4, 1'b0, 1'b1);
    push_seq(0, 3, 4, 1'b0, 9);
    drain("p4");
    wr(1, 0, 0, 1'b0, 1'b1);
    push_seq(1, 0, 16, 1'b0, 34);
    drain("p0");
    stop2[0] = 1'b1;
    push(1, 0, 1'b0, 1'b0, 0);
    drain("stop_w4");
    wr(1, 3, 2, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) push(1, c, 1'b0, 1'b0, 0);
    for (int c = 0; c < 3; c++) push(1, c, 1'b0, 1'b0, 0);
    drain("badch");
    chk("badch.period0", 32'(dut2.g_ch[0].u_ch.period), 0);
    chk("badch.period1", 32'(dut2.g_ch[1].u_ch.period), 0);
    chk("badch.period2", 32'(dut2.g_ch[2].u_ch.period), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
